conv_frame_sequencer: RTL and testbench
=======================================

// Module: conv_frame_sequencer
// PURPOSE
//  Sequences a multi-channel feature map from on-chip memory into the line-padding /
//  window datapath of one VGG16 conv layer.
//  Streams WIDTH*WIDTH pixels per channel, then issues FLUSH trailing cycles so the
//  padding logic can emit the bottom pad row. Loops over CHANNELS channels.
//  start/busy/done handshake toward the layer controller; stall backpressure from downstream.
// PARAMETERS
//  WIDTH     112        feature-map width = height (pixels)
//  CHANNELS  64         channels streamed per start
//  FLUSH     WIDTH+2    trailing flush cycles after each channel
//  ADDR_W    24         memory address width
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-high
//  start        in   1       begin sequence; sampled only in IDLE
//  cfg_base     in   ADDR_W  base address of channel 0; latched when start is accepted
//  stall        in   1       downstream not ready; freezes STREAM/FLUSH progress
//  busy         out  1       high from the cycle after start is accepted until DONE exits
//  done         out  1       one-cycle completion pulse
//  rd_en        out  1       memory read strobe (1-cycle read latency)
//  rd_addr      out  ADDR_W  read address
//  pix_valid    out  1       read data valid to padding block; rd_en delayed 1 cycle
//  flush_valid  out  1       flush cycle to padding block; registered, aligned like pix_valid
//  frame_start  out  1       pulses with pix_valid of pixel 0 of each channel
//  channel_idx  out  16      current channel index
//  stall_cycles out  32      stall counter; see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, counters and latched base are 0.
//  Reset mid-operation aborts at once; no partial done is issued.
//  FSM states: IDLE, STREAM, FLUSH, NEXT, DONE.
//   IDLE   : start=1 -> latch base; ch=0, pix=0, ch_off=0 -> STREAM. busy=0.
//   STREAM : rd_en = !stall (combinational); rd_addr = base + ch_off + pix.
//            Each non-stalled cycle advances pix by 1.
//            When pix=WIDTH*WIDTH-1 is issued: fcnt=0 -> FLUSH.
//   FLUSH  : each non-stalled cycle drives flush_valid (next cycle) and advances fcnt.
//            After FLUSH issued cycles: ch==CHANNELS-1 -> DONE, else -> NEXT.
//   NEXT   : single bubble cycle. ch++, ch_off += WIDTH*WIDTH, pix=0 -> STREAM.
//   DONE   : done=1 for this cycle only -> IDLE.
//  ch_off is an accumulator; no multiplier is used.
//  rd_addr holds its value while stalled: no pixel is skipped or duplicated.
//  Address sum wraps modulo 2^ADDR_W.
//  pix_valid and flush_valid are never high in the same cycle.
//  Downstream total valid = pix_valid | flush_valid.
//  stall has no effect in IDLE, NEXT or DONE.
//  start is ignored when not in IDLE. cfg_base changes after acceptance have no effect.
//  Latency: first rd_en is the cycle after start is sampled; first pix_valid one cycle later.
//  Unstalled run length, start accepted -> done cycle inclusive:
//   CHANNELS*(WIDTH*WIDTH + FLUSH) + (CHANNELS-1) + 1 cycles.
//  Each stalled STREAM/FLUSH cycle adds exactly one cycle.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined:
//   - stall_cycles is cleared when start is accepted.
//   - It increments on each cycle with stall=1 in STREAM or FLUSH, saturating at 2^32-1.
//   - It holds its value after done.
//  SEQ_PERF_CNT_EN undefined: stall_cycles is tied to 0 and the counter logic is absent.
// TESTING
//  T1 WIDTH=4,CHANNELS=2,FLUSH=6, base=0x100, no stall:
//     rd_addr 0x100..0x10F, 6 flush, 1 bubble, 0x110..0x11F, 6 flush.
//     done exactly 46 cycles after start is accepted; frame_start twice.
//  T2 Same as T1, stall=1 for 3 cycles when rd_addr=0x105:
//     rd_en=0 for those 3 cycles, rd_addr holds 0x105.
//     32 unique reads in total; done at cycle 49.
//  T3 start pulsed during STREAM and cfg_base changed to 0x200 mid-run:
//     sequence unaffected, single done, addresses still 0x100-based.
//  T4 rst asserted in FLUSH of channel 0:
//     all outputs 0 within the same cycle. A following start with base=0 restarts at rd_addr=0, channel_idx=0.
//  T5 CHANNELS=1,WIDTH=4,FLUSH=6: no NEXT bubble; done at cycle 23; channel_idx stays 0.
//  T6 T2 with SEQ_PERF_CNT_EN: stall_cycles=3 after done, 0 after next start.
//     Same run without the macro: stall_cycles=0 throughout.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: streams CHANNELS feature-map channels plus flush cycles into the padding/window datapath.
// Optional SEQ_PERF_CNT_EN enables the saturating stall_cycles counter; otherwise stall_cycles is tied to 0.
module conv_frame_sequencer #(
    parameter int WIDTH    = 112,
    parameter int CHANNELS = 64,
    parameter int FLUSH    = WIDTH + 2,
    parameter int ADDR_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic              flush_valid,
    output logic              frame_start,
    output logic [15:0]       channel_idx,
    output logic [31:0]       stall_cycles
);
    localparam int NPIX = WIDTH * WIDTH;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int FW   = $clog2(FLUSH + 1);
    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_FLUSH, S_NEXT, S_DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] base, ch_off;
    logic [PW-1:0] pix;
    logic [FW-1:0] fcnt;
    logic [15:0] ch;
    logic pix_last, flush_last, ch_last;
    assign pix_last    = pix == PW'(NPIX - 1);
    assign flush_last  = fcnt == FW'(FLUSH - 1);
    assign ch_last     = ch == 16'(CHANNELS - 1);
    assign rd_en       = state == S_STREAM && !stall;
    assign rd_addr     = base + ch_off + ADDR_W'(pix);
    assign busy        = state != S_IDLE;
    assign done        = state == S_DONE;
    assign channel_idx = ch;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = start ? S_STREAM : S_IDLE;
            S_STREAM: state_nx = (!stall && pix_last) ? S_FLUSH : S_STREAM;
            S_FLUSH:  state_nx = (!stall && flush_last) ? (ch_last ? S_DONE : S_NEXT) : S_FLUSH;
            S_NEXT:   state_nx = S_STREAM;
            default:  state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            base        <= '0;
            ch_off      <= '0;
            pix         <= '0;
            fcnt        <= '0;
            ch          <= '0;
            pix_valid   <= 1'b0;
            flush_valid <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            pix_valid   <= rd_en;
            flush_valid <= state == S_FLUSH && !stall;
            frame_start <= rd_en && pix == '0;
            if (state == S_IDLE && start) begin
                base   <= cfg_base;
                ch     <= '0;
                pix    <= '0;
                ch_off <= '0;
            end
            if (state == S_STREAM && !stall) begin
                pix <= pix + 1'b1;
                if (pix_last) fcnt <= '0;
            end
            if (state == S_FLUSH && !stall) fcnt <= fcnt + 1'b1;
            // channel offset accumulates instead of multiplying ch by the frame size
            if (state == S_NEXT) begin
                ch     <= ch + 1'b1;
                ch_off <= ch_off + ADDR_W'(NPIX);
                pix    <= '0;
            end
        end
    end
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] sc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sc <= '0;
        else if (state == S_IDLE && start) sc <= '0;
        else if ((state == S_STREAM || state == S_FLUSH) && stall && sc != '1) sc <= sc + 1'b1;
    end
    assign stall_cycles = sc;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: randomized self-checking bench against a slot-queue model of the sequence.
// Expected stall_cycles follows SEQ_PERF_CNT_EN the same way the design does.
module tb_conv_frame_sequencer;
    localparam int W = 4, FL = 6, NPIX = W * W;
    localparam int K_PIX = 0, K_FLUSH = 1, K_BUB = 2, K_DONE = 3;
    typedef struct {int kind; logic [23:0] addr; bit first; int ch;} slot_t;
    logic clk = 0, rst = 1, start = 0, stall = 0, sel_b = 0;
    logic [23:0] cfg_base = 0;
    logic busy_a, done_a, rd_en_a, pv_a, fv_a, fs_a, busy_b, done_b, rd_en_b, pv_b, fv_b, fs_b;
    logic [23:0] addr_a, addr_b;
    logic [15:0] ch_a, ch_b;
    logic [31:0] sc_a, sc_b;
    logic o_busy, o_done, o_rd_en, o_pv, o_fv, o_fs;
    logic [23:0] o_addr;
    logic [15:0] o_ch;
    logic [31:0] o_sc;
    int cmp = 0, errs = 0;
    always #5 clk = ~clk;
    conv_frame_sequencer #(.WIDTH(W), .CHANNELS(2), .FLUSH(FL), .ADDR_W(24)) dut_a (
        .clk(clk), .rst(rst), .start(start && !sel_b), .cfg_base(cfg_base), .stall(stall),
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_addr(addr_a), .pix_valid(pv_a),
        .flush_valid(fv_a), .frame_start(fs_a), .channel_idx(ch_a), .stall_cycles(sc_a));
    conv_frame_sequencer #(.WIDTH(W), .CHANNELS(1), .FLUSH(FL), .ADDR_W(24)) dut_b (
        .clk(clk), .rst(rst), .start(start && sel_b), .cfg_base(cfg_base), .stall(stall),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr(addr_b), .pix_valid(pv_b),
        .flush_valid(fv_b), .frame_start(fs_b), .channel_idx(ch_b), .stall_cycles(sc_b));
    assign o_busy  = sel_b ? busy_b : busy_a;
    assign o_done  = sel_b ? done_b : done_a;
    assign o_rd_en = sel_b ? rd_en_b : rd_en_a;
    assign o_pv    = sel_b ? pv_b : pv_a;
    assign o_fv    = sel_b ? fv_b : fv_a;
    assign o_fs    = sel_b ? fs_b : fs_a;
    assign o_addr  = sel_b ? addr_b : addr_a;
    assign o_ch    = sel_b ? ch_b : ch_a;
    assign o_sc    = sel_b ? sc_b : sc_a;

    task automatic test_reset(input string tag);
        cmp += 6;
        if (o_busy !== 0) begin errs++; $display("FAIL %s busy got %0b want 0", tag, o_busy); end
        if (o_done !== 0) begin errs++; $display("FAIL %s done got %0b want 0", tag, o_done); end
        if ({o_rd_en, o_pv, o_fv, o_fs} !== 4'b0) begin errs++; $display("FAIL %s strobes got %b want 0000", tag, {o_rd_en, o_pv, o_fv, o_fs}); end
        if (o_addr !== 0) begin errs++; $display("FAIL %s rd_addr got %h want 0", tag, o_addr); end
        if (o_ch !== 0) begin errs++; $display("FAIL %s channel_idx got %0d want 0", tag, o_ch); end
        if (o_sc !== 0) begin errs++; $display("FAIL %s stall_cycles got %0d want 0", tag, o_sc); end
    endtask

    // mode: 0 no stall, 1 three stalls at base+5, 2 random stall
    task automatic run(input bit b, input int nch, input logic [23:0] base, input int mode,
                       input bit poke, input int abort_at, input string tag);
        slot_t q[$];
        slot_t s;
        int cyc = 0, nstall = 0, reads = 0, frames = 0, done_cyc = -1, hold = 3, exp_done;
        bit pp = 0, pf = 0, pfs = 0, st;
        logic [31:0] exp_sc = 0, want_sc;
        for (int c = 0; c < nch; c++) begin
            for (int p = 0; p < NPIX; p++) q.push_back('{K_PIX, base + 24'(c * NPIX + p), p == 0, c});
            for (int f = 0; f < FL; f++) q.push_back('{K_FLUSH, 24'h0, 1'b0, c});
            if (c < nch - 1) q.push_back('{K_BUB, 24'h0, 1'b0, c});
        end
        q.push_back('{K_DONE, 24'h0, 1'b0, nch - 1});
        sel_b = b;
        @(negedge clk);
        cfg_base = base; start = 1; stall = 0;
        while (q.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = poke && cyc == 10;
            if (poke && cyc == 10) cfg_base = 24'h200;
            s = q[0];
            if (abort_at == cyc) begin
                stall = 0; rst = 1; #1;
                test_reset({tag, "_abort"});
                @(negedge clk); rst = 0;
                return;
            end
            st = mode == 0 ? 1'b0 : mode == 1 ? (s.kind == K_PIX && s.addr == base + 24'd5 && hold > 0)
                                              : ($urandom_range(0, 3) == 0);
            if (mode == 1 && st) hold--;
            stall = st;
            #1;
`ifdef SEQ_PERF_CNT_EN
            want_sc = exp_sc;
`else
            want_sc = 0;
`endif
            cmp += 8;
            if (o_rd_en !== (s.kind == K_PIX && !st)) begin errs++; $display("FAIL %s rd_en cyc %0d got %0b want %0b", tag, cyc, o_rd_en, s.kind == K_PIX && !st); end
            if (s.kind == K_PIX && o_addr !== s.addr) begin errs++; $display("FAIL %s rd_addr cyc %0d got %h want %h", tag, cyc, o_addr, s.addr); end
            if (o_pv !== pp) begin errs++; $display("FAIL %s pix_valid cyc %0d got %0b want %0b", tag, cyc, o_pv, pp); end
            if (o_fv !== pf) begin errs++; $display("FAIL %s flush_valid cyc %0d got %0b want %0b", tag, cyc, o_fv, pf); end
            if (o_fs !== pfs) begin errs++; $display("FAIL %s frame_start cyc %0d got %0b want %0b", tag, cyc, o_fs, pfs); end
            if (o_done !== (s.kind == K_DONE) || o_busy !== 1) begin errs++; $display("FAIL %s done/busy cyc %0d got %0b/%0b want %0b/1", tag, cyc, o_done, o_busy, s.kind == K_DONE); end
            if (o_ch !== 16'(s.ch)) begin errs++; $display("FAIL %s channel_idx cyc %0d got %0d want %0d", tag, cyc, o_ch, s.ch); end
            if (o_sc !== want_sc) begin errs++; $display("FAIL %s stall_cycles cyc %0d got %0d want %0d", tag, cyc, o_sc, want_sc); end
            if (o_rd_en) reads++;
            if (o_fs) frames++;
            if (o_done) done_cyc = cyc;
            if ((s.kind == K_PIX || s.kind == K_FLUSH) && st) begin
                nstall++; exp_sc++; pp = 0; pf = 0; pfs = 0;
            end else begin
                pp = s.kind == K_PIX; pf = s.kind == K_FLUSH; pfs = s.kind == K_PIX && s.first;
                void'(q.pop_front());
            end
        end
        start = 0; stall = 0;
        exp_done = nch * (NPIX + FL) + nch - 1 + 1 + nstall;
        @(negedge clk); #1;
`ifdef SEQ_PERF_CNT_EN
        want_sc = exp_sc;
`else
        want_sc = 0;
`endif
        cmp += 6;
        if (q.size() != 0) begin errs++; $display("FAIL %s timeout got %0d slots left want 0", tag, q.size()); end
        if (done_cyc != exp_done) begin errs++; $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, exp_done); end
        if (reads != nch * NPIX) begin errs++; $display("FAIL %s reads got %0d want %0d", tag, reads, nch * NPIX); end
        if (frames != nch) begin errs++; $display("FAIL %s frame_starts got %0d want %0d", tag, frames, nch); end
        if (o_busy !== 0 || o_done !== 0 || o_fv !== 0) begin errs++; $display("FAIL %s idle_after got busy %0b done %0b fv %0b want 0", tag, o_busy, o_done, o_fv); end
        if (o_sc !== want_sc) begin errs++; $display("FAIL %s stall_cycles_after got %0d want %0d", tag, o_sc, want_sc); end
    endtask

    task automatic test_no_stall();      run(0, 2, 24'h100, 0, 0, 0, "t1_nostall"); endtask
    task automatic test_fixed_stall();   run(0, 2, 24'h100, 1, 0, 0, "t2_stall"); endtask
    task automatic test_counter_clear(); run(0, 2, 24'h100, 0, 0, 0, "t6_clear"); endtask
    task automatic test_ignore_start();  run(0, 2, 24'h100, 0, 1, 0, "t3_ignore"); endtask
    task automatic test_random_stall();
        for (int i = 0; i < 4; i++) run(0, 2, 24'($urandom), 2, 0, 0, "rand_stall");
        run(0, 2, 24'hFFFFF0, 2, 0, 0, "wrap");
    endtask
    task automatic test_reset_mid();
        run(0, 2, 24'h100, 0, 0, 19, "t4_mid");
        run(0, 2, 24'h000, 0, 0, 0, "t4_restart");
    endtask
    task automatic test_single_channel();
        run(1, 1, 24'h100, 0, 0, 0, "t5_single");
        run(1, 1, 24'($urandom), 2, 0, 0, "t5_rand");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        test_reset("reset");
        rst = 0;
        test_no_stall();
        test_fixed_stall();
        test_counter_clear();
        test_ignore_start();
        test_random_stall();
        test_reset_mid();
        test_single_channel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
